// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the regfile write port between writeback and a queued long-latency requester
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   pipe_we/addr/data            in-order writeback write request
//   pipe_stall                   writeback write not performed this cycle
//   ext_valid/addr/data          long-latency result, accepted when ext_ready
//   ext_ready                    queue has room
//   chk_addr, chk_hit            decode interlock query against queued entries
//   write_en/reg_write_addr/data regfile write port
module wb_port_arbiter #(
    parameter int W        = 32,
    parameter int A        = 5,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pipe_we,
    input  logic [A-1:0] pipe_addr,
    input  logic [W-1:0] pipe_data,
    output logic         pipe_stall,
    input  logic         ext_valid,
    input  logic [A-1:0] ext_addr,
    input  logic [W-1:0] ext_data,
    output logic         ext_ready,
    input  logic [A-1:0] chk_addr,
    output logic         chk_hit,
    output logic         write_en,
    output logic [A-1:0] reg_write_addr,
    output logic [W-1:0] reg_write_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [A-1:0]  addr_q [DEPTH];
    logic [W-1:0]  data_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, idx;
    logic [CW-1:0] count_q, count_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          push, grant, hit;

    always_comb begin
        ext_ready      = !rst && count_q != CW'(DEPTH);
        push           = ext_valid && ext_ready;
        // The queue wins an idle slot, or steals a busy one once it has waited MAX_WAIT cycles.
        grant          = !rst && count_q != '0 && (!pipe_we || wait_q == WW'(MAX_WAIT));
        pipe_stall     = grant && pipe_we;
        reg_write_addr = grant ? addr_q[rd_q] : (!rst && pipe_we) ? pipe_addr : '0;
        reg_write_data = grant ? data_q[rd_q] : (!rst && pipe_we) ? pipe_data : '0;
        // r0 writes consume their slot but never reach the regfile.
        write_en       = (grant || (!rst && pipe_we)) && reg_write_addr != '0;
        rd_d           = rd_q + PW'(grant);
        wr_d           = wr_q + PW'(push);
        count_d        = count_q + CW'(push) - CW'(grant);
        wait_d         = (count_q == '0 || grant) ? '0 :
                         (wait_q == WW'(MAX_WAIT)) ? wait_q : wait_q + WW'(1);
        // Only the count_q live slots starting at the head are compared; stale slots are ignored.
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_q + PW'(i);
            hit = hit | (CW'(i) < count_q && addr_q[idx] == chk_addr);
        end
        chk_hit = !rst && chk_addr != '0 && hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            wait_q  <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            wait_q  <= wait_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_q] <= ext_addr;
            data_q[wr_q] <= ext_data;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and randomized checks of wb_port_arbiter against a queue-based model
module tb_wb_port_arbiter;
    localparam int W = 32, A = 5, DEPTH = 2, MAX_WAIT = 4;

    typedef struct {
        logic [A-1:0] addr;
        logic [W-1:0] data;
    } ent_t;

    logic         clk = 1'b0, rst = 1'b1;
    logic         pipe_we = 1'b0, ext_valid = 1'b0;
    logic [A-1:0] pipe_addr = '0, ext_addr = '0, chk_addr = '0;
    logic [W-1:0] pipe_data = '0, ext_data = '0;
    logic         pipe_stall, ext_ready, chk_hit, write_en;
    logic [A-1:0] reg_write_addr;
    logic [W-1:0] reg_write_data;

    ent_t         q[$];
    int           mwait = 0;
    int           n_chk = 0, n_fail = 0;
    logic         obs_we, obs_stall, obs_ready, obs_hit;
    logic [A-1:0] obs_addr;
    logic [W-1:0] obs_data;

    wb_port_arbiter #(.W(W), .A(A), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
        .ext_valid(ext_valid), .ext_addr(ext_addr), .ext_data(ext_data), .ext_ready(ext_ready),
        .chk_addr(chk_addr), .chk_hit(chk_hit),
        .write_en(write_en), .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare every output with the model, then advance the model at the edge.
    task automatic cycle(input logic r, input logic pw, input logic [A-1:0] pa, input logic [W-1:0] pd,
                         input logic ev, input logic [A-1:0] ea, input logic [W-1:0] ed,
                         input logic [A-1:0] ca);
        logic         g, rdy, hit, e_we;
        logic [A-1:0] e_addr;
        logic [W-1:0] e_data;
        ent_t         e;
        rst = r; pipe_we = pw; pipe_addr = pa; pipe_data = pd;
        ext_valid = ev; ext_addr = ea; ext_data = ed; chk_addr = ca;
        #3;
        rdy = !r && q.size() < DEPTH;
        g   = !r && q.size() != 0 && (!pw || mwait == MAX_WAIT);
        hit = 1'b0;
        if (!r && ca != 0) foreach (q[k]) if (q[k].addr == ca) hit = 1'b1;
        e_addr = '0;
        e_data = '0;
        if (g) begin
            e_addr = q[0].addr;
            e_data = q[0].data;
        end else if (!r && pw) begin
            e_addr = pa;
            e_data = pd;
        end
        e_we = (g || (!r && pw)) && e_addr != 0;
        check("write_en", 64'(write_en), 64'(e_we));
        check("wr_addr", 64'(reg_write_addr), 64'(e_addr));
        check("wr_data", 64'(reg_write_data), 64'(e_data));
        check("pipe_stall", 64'(pipe_stall), 64'(g && pw));
        check("ext_ready", 64'(ext_ready), 64'(rdy));
        check("chk_hit", 64'(chk_hit), 64'(hit));
        obs_we = write_en; obs_stall = pipe_stall; obs_ready = ext_ready; obs_hit = chk_hit;
        obs_addr = reg_write_addr; obs_data = reg_write_data;
        @(posedge clk);
        if (r) begin
            q.delete();
            mwait = 0;
        end else begin
            if (q.size() == 0 || g) mwait = 0;
            else if (mwait < MAX_WAIT) mwait++;
            if (g) void'(q.pop_front());
            if (ev && rdy) begin
                e.addr = ea;
                e.data = ed;
                q.push_back(e);
            end
        end
        #1;
    endtask

    initial begin
        logic         pw;
        logic [A-1:0] pa;
        logic [W-1:0] pd;
        @(posedge clk);
        #1;
        // reset with both requesters active
        repeat (2) begin
            cycle(1, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2, 5'd4);
            check("rst_we", 64'(obs_we), 0);
            check("rst_ready", 64'(obs_ready), 0);
            check("rst_stall", 64'(obs_stall), 0);
        end
        // idle drain
        cycle(0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0);
        check("rel_ready", 64'(obs_ready), 1);
        check("push_cyc_we", 64'(obs_we), 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        check("drain_we", 64'(obs_we), 1);
        check("drain_addr", 64'(obs_addr), 5);
        check("drain_data", 64'(obs_data), 32'hDEADBEEF);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        check("drain_done", 64'(obs_we), 0);
        // pipe priority then forced drain
        cycle(0, 0, 0, 0, 1, 5'd7, 32'h11, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 5'd3, 32'h100 + 32'(i), 0, 0, 0, 0);
            check("prio_pipe", 64'(obs_addr), 3);
        end
        cycle(0, 1, 5'd3, 32'h104, 0, 0, 0, 0);
        check("force_stall", 64'(obs_stall), 1);
        check("force_addr", 64'(obs_addr), 7);
        check("force_data", 64'(obs_data), 32'h11);
        cycle(0, 1, 5'd3, 32'h104, 0, 0, 0, 0);
        check("replay_data", 64'(obs_data), 32'h104);
        check("replay_stall", 64'(obs_stall), 0);
        // full and simultaneous push/pop
        cycle(0, 1, 5'd1, 32'h1, 1, 5'd9, 32'h9, 0);
        cycle(0, 1, 5'd1, 32'h2, 1, 5'd10, 32'hA, 0);
        cycle(0, 1, 5'd1, 32'h3, 1, 5'd11, 32'hB, 0);
        check("full_ready", 64'(obs_ready), 0);
        cycle(0, 0, 0, 0, 1, 5'd11, 32'hB, 0);
        check("full_pop_ready", 64'(obs_ready), 0);
        check("order0", 64'(obs_addr), 9);
        cycle(0, 0, 0, 0, 1, 5'd11, 32'hB, 0);
        check("ready_back", 64'(obs_ready), 1);
        check("order1", 64'(obs_addr), 10);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        check("order2", 64'(obs_addr), 11);
        // r0 handling
        cycle(0, 1, 5'd0, 32'h55, 1, 5'd0, 32'h66, 5'd0);
        check("r0_pipe_we", 64'(obs_we), 0);
        check("r0_pipe_stall", 64'(obs_stall), 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 5'd0);
        check("r0_fifo_we", 64'(obs_we), 0);
        check("r0_hit", 64'(obs_hit), 0);
        // interlock
        cycle(0, 1, 5'd2, 32'h1, 1, 5'd12, 32'hC, 5'd12);
        check("hit_push_cyc", 64'(obs_hit), 0);
        cycle(0, 1, 5'd2, 32'h2, 0, 0, 0, 5'd12);
        check("hit12", 64'(obs_hit), 1);
        cycle(0, 1, 5'd2, 32'h3, 0, 0, 0, 5'd13);
        check("hit13", 64'(obs_hit), 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 5'd12);
        check("hit_pop_cyc", 64'(obs_hit), 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 5'd12);
        check("hit_stale", 64'(obs_hit), 0);
        // randomized traffic with occasional reset; a stalled pipe write is re-presented
        pw = 0; pa = '0; pd = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!obs_stall) begin
                pw = $urandom_range(0, 2) != 0;
                pa = A'($urandom_range(0, 3));
                pd = $urandom;
            end
            cycle($urandom_range(0, 199) == 0, pw, pa, pd, 1'($urandom_range(0, 1)),
                  A'($urandom_range(0, 3)), $urandom, A'($urandom_range(0, 3)));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order writeback stage and a long-latency requester (mul/div unit or delayed load return).
- Long-latency results are queued in a small FIFO and drained into idle writeback slots.
- A starvation counter forces a FIFO drain by stalling the pipeline when it has held the port too long.
- Sits between writeback (its write_en / reg_write_addr / reg_write_data) and regfile; exports an interlock query for decode.

Parameters:
- W, `WORD_WIDTH (32): data width.
- A, `REG_ADDR_W (5): register address width.
- DEPTH, 2: FIFO entries; power of two, ≥2.
- MAX_WAIT, 4: consecutive cycles a non-empty FIFO may go ungranted before a forced drain; ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- pipe_we  in  1  writeback stage requests a write (writeback write_en).
- pipe_addr  in  A  writeback destination (writeback reg_write_addr).
- pipe_data  in  W  writeback data (writeback reg_write_data).
- pipe_stall  out  1  pipe write NOT performed this cycle; pipeline holds and re-presents it.
- ext_valid  in  1  long-latency result valid.
- ext_addr  in  A  its destination.
- ext_data  in  W  its data.
- ext_ready  out  1  FIFO can accept; transfer occurs when ext_valid && ext_ready.
- chk_addr  in  A  decode interlock query address.
- chk_hit  out  1  chk_addr != 0 and matches a valid FIFO entry.
- write_en  out  1  regfile write enable.
- reg_write_addr  out  A  regfile write address.
- reg_write_data  out  W  regfile write data.

Behaviour:
- State: FIFO storage (addr, data), rd_ptr, wr_ptr, count (0..DEPTH), wait_cnt (0..MAX_WAIT). All cleared on rst at posedge clk; FIFO data contents need not be cleared.
- While rst is high: write_en=0, pipe_stall=0, ext_ready=0, chk_hit=0, reg_write_addr=0, reg_write_data=0.
- ext_ready = (count < DEPTH), combinational from count; no dependence on ext_valid.
- Push on ext_valid && ext_ready at posedge; no bypass: a pushed entry is eligible for grant the cycle after push, never the push cycle.
- Each cycle, combinational grant:
  - fifo_grant = (count != 0) && (!pipe_we || wait_cnt == MAX_WAIT).
  - fifo_grant: outputs = FIFO head; write_en=1; pop at posedge; pipe_stall = pipe_we.
  - else if pipe_we: outputs = pipe_addr/pipe_data; write_en=1; pipe_stall=0.
  - else: write_en=0, addr=0, data=0.
- Writes to address 0 from either source: write_en forced 0, but the slot counts as granted (FIFO pops; pipe not stalled).
- Push and pop in the same cycle: count unchanged, both pointers advance. Full plus pop: ext_ready was 0, so no push that cycle; ready returns the cycle after.
- Pointers wrap modulo DEPTH.
- wait_cnt at posedge:
  - 0 if count==0 or fifo_grant.
  - else min(wait_cnt+1, MAX_WAIT).
- A forced drain occurs at most once per MAX_WAIT+1 cycles while the pipe writes continuously.
- chk_hit: combinational compare of chk_addr against all valid entries only (count-qualified; stale slots ignored). Decode must stall any reader or writer of a hit register so pipe/ext ordering to one register is never violated.
- Reset mid-operation drops all queued entries; the requester must be reset concurrently.

Test Plan:
- Reset: hold rst 2 cycles with ext_valid=1, pipe_we=1 -> write_en=0, ext_ready=0, pipe_stall=0. Release -> ext_ready=1, count=0.
- Idle drain: pipe_we=0; push (addr 5, 0xDEADBEEF) at cycle t -> write_en=1, addr=5, data=0xDEADBEEF at t+1 only; count back to 0 at t+2.
- Pipe priority: FIFO holds (7, 0x11); pipe_we=1 on consecutive cycles with addr 3, data 0x100+i -> pipe writes granted for 4 cycles (wait_cnt 0→4). 5th cycle: FIFO write addr 7, pipe_stall=1. Next cycle: stalled pipe write granted, wait_cnt=0.
- Full / simultaneous: push 2 entries -> ext_ready=0 with ext_valid held. Pop cycle: no push accepted. Next cycle: ready=1 and push plus next pop proceed; entry order preserved (FIFO order 9, 10, 11).
- r0: pipe write to addr 0 -> write_en=0, pipe_stall=0. FIFO entry with addr 0 popped with write_en=0, chk_hit never asserts for chk_addr=0.
- Interlock: FIFO holds addr 12 -> chk_addr=12 gives chk_hit=1; chk_addr=13 gives 0. After the pop cycle, chk_addr=12 gives 0, including a stale slot still holding 12.
